// File: rtl/comp_seq_ctrl.sv
// Sequential WIDTH-bit magnitude compare built from one 2-bit comparator slice.
// Optional COMP_SEQ_EARLY_EXIT_EN: stop on the first unequal slice.
module comp_gate (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic       gt,
   output logic       lt,
   output logic       eq
);
   assign gt = a > b;
   assign lt = a < b;
   assign eq = a == b;
endmodule

module comp_seq_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             greater,
   output logic             lesser,
   output logic             equal
);
   localparam int N  = WIDTH / 2;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] K_TOP = KW'(N - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [KW-1:0]    k_q, k_d;
   logic             done_q, done_d;
   logic             gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;

   logic [1:0] sl_a, sl_b;
   logic       sl_gt, sl_lt, sl_eq;

   assign sl_a = 2'(a_q >> {k_q, 1'b0});
   assign sl_b = 2'(b_q >> {k_q, 1'b0});

   comp_gate u_gate (
      .a  (sl_a),
      .b  (sl_b),
      .gt (sl_gt),
      .lt (sl_lt),
      .eq (sl_eq)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      k_d     = k_q;
      done_d  = 1'b0;
      gt_d    = gt_q;
      lt_d    = lt_q;
      eq_d    = eq_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               k_d     = K_TOP;
               gt_d    = 1'b0;
               lt_d    = 1'b0;
               eq_d    = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
`ifdef COMP_SEQ_EARLY_EXIT_EN
            if (!sl_eq) begin
               gt_d    = sl_gt;
               lt_d    = sl_lt;
               eq_d    = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (k_q == '0) begin
               eq_d    = 1'b1;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               k_d = k_q - KW'(1);
            end
`else
            // gt/lt already set means an earlier slice decided; keep it
            if (!sl_eq && !(gt_q || lt_q)) begin
               gt_d = sl_gt;
               lt_d = sl_lt;
            end
            if (k_q == '0) begin
               eq_d    = sl_eq && !(gt_q || lt_q);
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               k_d = k_q - KW'(1);
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         k_q     <= K_TOP;
         done_q  <= 1'b0;
         gt_q    <= 1'b0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         k_q     <= k_d;
         done_q  <= done_d;
         gt_q    <= gt_d;
         lt_q    <= lt_d;
         eq_q    <= eq_d;
      end
   end

   assign busy    = (state_q == RUN);
   assign done    = done_q;
   assign greater = gt_q;
   assign lesser  = lt_q;
   assign equal   = eq_q;

endmodule

// File: tb/tb_comp_seq_ctrl.sv
// Directed self-checking bench for comp_seq_ctrl at WIDTH=8.
// Latency expectations follow COMP_SEQ_EARLY_EXIT_EN when defined.
module tb_comp_seq_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a, b;
   logic       busy, done, greater, lesser, equal;

   int checks = 0;
   int failures = 0;

`ifdef COMP_SEQ_EARLY_EXIT_EN
   localparam int EE = 1;
`else
   localparam int EE = 0;
`endif

   comp_seq_ctrl #(.WIDTH(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .greater (greater),
      .lesser  (lesser),
      .equal   (equal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // flags packed as {greater,lesser,equal}
   task automatic chk_out(input string tag, input int bsy, input int dn,
                          input int flags);
      chk({tag, ".busy"}, int'(busy), bsy);
      chk({tag, ".done"}, int'(done), dn);
      chk({tag, ".flags"}, int'({greater, lesser, equal}), flags);
   endtask

   task automatic start_op(input logic [7:0] av, input logic [7:0] bv);
      @(negedge clk);
      a = av;
      b = bv;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // counts edges after acceptance until done is seen, bounded
   task automatic wait_done(input string tag, input int exp_lat,
                            input int exp_flags, input int lat0);
      int lat;
      lat = lat0;
      while (!done && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, ".latency"}, lat, exp_lat);
      chk_out({tag, ".result"}, 0, 1, exp_flags);
   endtask

   initial begin
      int lat;
      int seen;
      rst = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_out("reset", 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      start_op(8'hA5, 8'hA5);
      chk_out("eq.accept", 1, 0, 0);
      wait_done("eq", 4, 3'b001, 0);

      start_op(8'h80, 8'h7F);
      wait_done("gt", EE ? 1 : 4, 3'b100, 0);

      start_op(8'h12, 8'h13);
      wait_done("lt", 4, 3'b010, 0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk_out("lt.hold", 0, 0, 3'b010);
      end

      // second start during busy must be ignored
      start_op(8'h00, 8'hFF);
      a = 8'hFF;
      b = 8'h00;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("ign", EE ? 1 : 4, 3'b010, 1);
      seen = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         seen += int'(done) + int'(busy);
      end
      chk("ign.no_second", seen, 0);

      // abort mid-run
      start_op(8'h40, 8'h40);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_out("abort", 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         seen += int'(done);
      end
      chk("abort.no_done", seen, 0);
      start_op(8'h03, 8'h02);
      wait_done("post_abort", 4, 3'b100, 0);

      // back-to-back: start raised in the done cycle
      start_op(8'hC0, 8'h40);
      wait_done("b2b1", EE ? 1 : 4, 3'b100, 0);
      a = 8'h01;
      b = 8'h01;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk_out("b2b2.accept", 1, 0, 0);
      wait_done("b2b2", 4, 3'b001, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
